// File: rtl/uart_tx_if.sv
// Parallel-side request and serial-side status bundle for uart_tx.
// The master drives a byte plus framing options; the slave returns the line and busy.
interface uart_tx_if #(
  parameter int frame_data = 8
);
  logic [frame_data-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ,
    output tx_out, busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter clocked at the bit rate: start, LSB-first data, optional parity, stop.
// Line and busy are registered; a request is only taken while idle.
module uart_tx #(
  parameter int frame_data = 8
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);

  localparam int CW = (frame_data > 1) ? $clog2(frame_data) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(frame_data - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [frame_data-1:0] data_q, data_n;
  logic                  par_en_q, par_en_n;
  logic                  par_typ_q, par_typ_n;
  logic                  tx_q, tx_n;
  logic                  busy_q, busy_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      data_q    <= data_n;
      par_en_q  <= par_en_n;
      par_typ_q <= par_typ_n;
      tx_q      <= tx_n;
      busy_q    <= busy_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    data_n    = data_q;
    par_en_n  = par_en_q;
    par_typ_n = par_typ_q;

    case (state)
      IDLE: begin
        if (bus.data_valid) begin
          state_n   = START;
          data_n    = bus.p_data;
          par_en_n  = bus.par_en;
          par_typ_n = bus.par_typ;
        end
      end
      START: begin
        state_n = DATA;
        cnt_n   = '0;
      end
      DATA: begin
        // Counter saturates on the last bit so it never wraps inside a frame.
        if (cnt == LAST_BIT) begin
          state_n = par_en_q ? PARITY : STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PARITY: state_n = STOP;
      STOP: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Line value is decoded from the upcoming state so tx_out comes straight off a flop.
  always_comb begin
    tx_n   = 1'b1;
    busy_n = 1'b1;
    case (state_n)
      IDLE:    busy_n = 1'b0;
      START:   tx_n   = 1'b0;
      DATA:    tx_n   = data_n[cnt_n];
      PARITY:  tx_n   = (^data_n) ^ par_typ_n;
      STOP:    tx_n   = 1'b1;
      default: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
      end
    endcase
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table-driven frames, hand sequences for hold/reset corners,
// and random traffic against a bit-queue model with a one-sample-per-bit receiver.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_if #(.frame_data(8)) bus ();

  uart_tx #(.frame_data(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Reference model: a frame becomes a queue of line bits; one bit leaves per clock.
  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
  } acc_t;

  bit   line_q[$];
  acc_t acc_q[$];
  logic exp_tx;
  logic exp_busy;

  // Receiver state (one sample per bit period, same clock as the transmitter)
  bit         rx_active;
  int         rx_cnt;
  logic [7:0] rx_data;
  logic       rx_pe, rx_pt, rx_par_done, rx_perr;

  task automatic model_edge(input logic dv, input logic [7:0] d, input logic pe, input logic pt);
    if (!exp_busy && dv) begin
      acc_t a;
      line_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) line_q.push_back(d[i]);
      if (pe) line_q.push_back((^d) ^ pt);
      line_q.push_back(1'b1);
      a.d = d; a.pe = pe; a.pt = pt;
      acc_q.push_back(a);
    end
    if (line_q.size() > 0) begin
      exp_tx   = line_q.pop_front();
      exp_busy = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end
  endtask

  task automatic model_reset();
    if (line_q.size() > 0) void'(acc_q.pop_back());
    line_q.delete();
    exp_tx    = 1'b1;
    exp_busy  = 1'b0;
    rx_active = 1'b0;
  endtask

  task automatic rx_step(input logic b);
    if (!rx_active) begin
      if (b == 1'b0) begin
        rx_active   = 1'b1;
        rx_cnt      = 0;
        rx_data     = '0;
        rx_par_done = 1'b0;
        rx_perr     = 1'b0;
        chk("rx_start_has_request", acc_q.size(), 1);
        if (acc_q.size() > 0) begin
          rx_pe = acc_q[0].pe;
          rx_pt = acc_q[0].pt;
        end else begin
          rx_pe = 1'b0;
          rx_pt = 1'b0;
        end
      end
    end else if (rx_cnt < 8) begin
      rx_data[rx_cnt] = b;
      rx_cnt++;
    end else if (rx_pe && !rx_par_done) begin
      rx_perr     = (b != ((^rx_data) ^ rx_pt));
      rx_par_done = 1'b1;
    end else begin
      acc_t a;
      chk1("rx_stop_error", b, 1'b1);
      chk1("rx_parity_error", rx_perr, 1'b0);
      if (acc_q.size() > 0) begin
        a = acc_q.pop_front();
        chk("rx_data", {24'b0, rx_data}, {24'b0, a.d});
      end
      rx_active = 1'b0;
    end
  endtask

  // Drive inputs for the next rising edge, then sample on the falling edge.
  task automatic cycle(input logic dv, input logic [7:0] d, input logic pe, input logic pt);
    bus.data_valid = dv;
    bus.p_data     = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    model_edge(dv, d, pe, pt);
    @(negedge clk);
    chk1("tx_out", bus.tx_out, exp_tx);
    chk1("busy", bus.busy, exp_busy);
    rx_step(bus.tx_out);
  endtask

  typedef struct {
    logic [7:0]  d;
    logic        pe;
    logic        pt;
    logic [10:0] bits;  // bit 0 is the first bit on the line
    int          len;
  } vec_t;

  vec_t tv[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{d: 8'h55, pe: 1'b1, pt: 1'b1, bits: 11'b110_1010_1010, len: 11};
    tv[1] = '{d: 8'hFF, pe: 1'b1, pt: 1'b0, bits: 11'b101_1111_1110, len: 11};
    tv[2] = '{d: 8'h00, pe: 1'b0, pt: 1'b0, bits: 11'b010_0000_0000, len: 10};
    tv[3] = '{d: 8'hA5, pe: 1'b1, pt: 1'b1, bits: 11'b111_0100_1010, len: 11};
    tv[4] = '{d: 8'h01, pe: 1'b1, pt: 1'b0, bits: 11'b110_0000_0010, len: 11};

    bus.data_valid = 1'b0;
    bus.p_data     = '0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    rx_active      = 1'b0;
    exp_tx         = 1'b1;
    exp_busy       = 1'b0;

    #2 rst = 1'b0;
    #1;
    chk1("reset_tx", bus.tx_out, 1'b1);
    chk1("reset_busy", bus.busy, 1'b0);
    bus.data_valid = 1'b1;
    @(negedge clk);
    chk1("reset_held_tx", bus.tx_out, 1'b1);
    chk1("reset_held_busy", bus.busy, 1'b0);
    #2 rst = 1'b1;
    repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Table-driven frames; inputs are scrambled after acceptance.
    for (int v = 0; v < 5; v++) begin
      cycle(1'b1, tv[v].d, tv[v].pe, tv[v].pt);
      for (int i = 0; i < tv[v].len; i++) begin
        if (i > 0) cycle(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
        chk1($sformatf("vec%0d_bit%0d", v, i), bus.tx_out, tv[v].bits[i]);
        chk1($sformatf("vec%0d_busy%0d", v, i), bus.busy, 1'b1);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      chk1($sformatf("vec%0d_idle_tx", v), bus.tx_out, 1'b1);
      chk1($sformatf("vec%0d_idle_busy", v), bus.busy, 1'b0);
    end

    // data_valid held high, options toggled mid-frame: first frame is even parity.
    for (int c = 0; c < 26; c++) begin
      cycle(1'b1, 8'hA5, 1'(c % 3 != 1), 1'(c % 2));
      if (c == 9)  chk1("hold_parity_bit", bus.tx_out, 1'b0);
      if (c == 10) chk1("hold_stop_bit", bus.tx_out, 1'b1);
      if (c == 11) chk1("hold_gap_busy", bus.busy, 1'b0);
      if (c == 12) begin
        chk1("hold_second_start_tx", bus.tx_out, 1'b0);
        chk1("hold_second_start_busy", bus.busy, 1'b1);
      end
    end
    repeat (14) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset during data bit 4 of 0xC3 (bit 4 is 0 on the line).
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk1("pre_reset_bit4", bus.tx_out, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk1("async_reset_tx", bus.tx_out, 1'b1);
    chk1("async_reset_busy", bus.busy, 1'b0);
    model_reset();
    bus.data_valid = 1'b1;
    @(negedge clk);
    chk1("in_reset_tx", bus.tx_out, 1'b1);
    #2 rst = 1'b1;
    repeat (4) cycle(1'b0, 8'hC3, 1'b0, 1'b0);

    // Request on the very first edge after reset release.
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    cycle(1'b1, 8'h5A, 1'b1, 1'b1);
    chk1("first_edge_accept", bus.tx_out, 1'b0);
    repeat (12) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic with loopback decode.
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    repeat (15) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rx_frames_outstanding", acc_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
